// File: rtl/icache_refill_unit_pkg.sv
// Shared types and default geometry for the icache refill path.
// The top module derives its own BEATS from its parameters; these are the defaults.
package interconnect_pkg;

    localparam int LINE_BYTES = 32;
    localparam int BEAT_BITS  = 64;
    localparam int BEATS      = LINE_BYTES * 8 / BEAT_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        COLLECT = 2'd2,
        FILL    = 2'd3
    } icache_refill_state_e;

    // Index width that stays legal for a single-beat line.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_refill_unit_if.sv
// Bundle of the miss, line-request, read-beat and fill signals around the refill unit.
// "master" is the refill unit itself; "slave" is the cache front end plus the AXI port.
interface icache_refill_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BYTES = interconnect_pkg::LINE_BYTES
);

    logic                    miss_valid_i;
    logic                    miss_ready_o;
    logic [ADDR_WIDTH-1:0]   miss_addr_i;
    logic                    flush_i;

    logic                    line_req_valid_o;
    logic                    line_req_ready_i;
    logic [ADDR_WIDTH-1:0]   line_req_addr_o;

    logic                    beat_valid_i;
    logic                    beat_ready_o;
    logic [DATA_WIDTH-1:0]   beat_data_i;
    logic                    beat_last_i;
    logic [1:0]              beat_resp_i;

    logic                    fill_we_o;
    logic [ADDR_WIDTH-1:0]   fill_addr_o;
    logic [LINE_BYTES*8-1:0] fill_line_o;
    logic                    fill_err_o;
    logic                    busy_o;

    modport master (
        input  miss_valid_i, miss_addr_i, flush_i,
        input  line_req_ready_i,
        input  beat_valid_i, beat_data_i, beat_last_i, beat_resp_i,
        output miss_ready_o,
        output line_req_valid_o, line_req_addr_o,
        output beat_ready_o,
        output fill_we_o, fill_addr_o, fill_line_o, fill_err_o, busy_o
    );

    modport slave (
        output miss_valid_i, miss_addr_i, flush_i,
        output line_req_ready_i,
        output beat_valid_i, beat_data_i, beat_last_i, beat_resp_i,
        input  miss_ready_o,
        input  line_req_valid_o, line_req_addr_o,
        input  beat_ready_o,
        input  fill_we_o, fill_addr_o, fill_line_o, fill_err_o, busy_o
    );

endinterface

// File: rtl/icache_refill_unit_line_buffer.sv
// Beat-indexed line storage: one register per beat slot, presented as a flat line.
// Slots are kept separate so each has exactly one writer.
module icache_line_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int SLOTS      = 4,
    parameter int IDX_W      = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        we_i,
    input  logic [IDX_W-1:0]            idx_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic [SLOTS*DATA_WIDTH-1:0] line_o
);

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        logic [DATA_WIDTH-1:0] r_slot;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_slot <= '0;
            end else if (we_i && (idx_i == IDX_W'(gi))) begin
                r_slot <= data_i;
            end
        end

        assign line_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_slot;
    end

endmodule

// File: rtl/icache_refill_unit.sv
// Icache miss refill: issues one line request, gathers the read burst, then writes
// the assembled line (or reports an error) in a single FILL cycle.
module icache_refill_unit
    import interconnect_pkg::icache_refill_state_e, interconnect_pkg::IDLE,
           interconnect_pkg::REQ, interconnect_pkg::COLLECT, interconnect_pkg::FILL;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BYTES = interconnect_pkg::LINE_BYTES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    icache_refill_unit_if.master bus
);

    localparam int BEATS = LINE_BYTES * 8 / DATA_WIDTH;
    localparam int IDX_W = interconnect_pkg::idx_width(BEATS);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

    icache_refill_state_e r_state;
    icache_refill_state_e w_state_next;

    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [IDX_W-1:0]          r_beat_cnt;
    logic                      r_err;
    logic                      r_drop;
    logic                      r_last_slot_done;

    logic                      w_miss_hs;
    logic                      w_req_hs;
    logic                      w_beat_hs;
    logic                      w_at_last;
    logic                      w_beat_bad;
    logic                      w_buf_we;
    logic                      w_flush_hit;
    logic [LINE_BYTES*8-1:0]   w_fill_line;

    assign w_miss_hs = (r_state == IDLE)    && bus.miss_valid_i;
    assign w_req_hs  = (r_state == REQ)     && bus.line_req_ready_i;
    assign w_beat_hs = (r_state == COLLECT) && bus.beat_valid_i;
    assign w_at_last = (r_beat_cnt == LAST_IDX);

    // A burst is well formed only if beat_last coincides with the final slot.
    assign w_beat_bad = (bus.beat_resp_i != 2'b00)
                     || (bus.beat_last_i && !w_at_last)
                     || (w_at_last && !bus.beat_last_i);

    // Once the final slot holds data, overrun beats of a long burst are dropped.
    assign w_buf_we    = w_beat_hs && !r_last_slot_done;
    assign w_flush_hit = bus.flush_i && ((r_state == REQ) || (r_state == COLLECT));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        bus.miss_ready_o     = 1'b0;
        bus.line_req_valid_o = 1'b0;
        bus.beat_ready_o     = 1'b0;
        bus.fill_we_o        = 1'b0;
        bus.fill_err_o       = 1'b0;
        unique case (r_state)
            IDLE: begin
                bus.miss_ready_o = 1'b1;
                if (bus.miss_valid_i) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                bus.line_req_valid_o = 1'b1;
                if (w_req_hs) begin
                    w_state_next = COLLECT;
                end
            end
            COLLECT: begin
                bus.beat_ready_o = 1'b1;
                if (w_beat_hs && bus.beat_last_i) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                bus.fill_we_o  = !r_err && !r_drop;
                bus.fill_err_o = r_err && !r_drop;
                w_state_next   = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr           <= '0;
            r_beat_cnt       <= '0;
            r_err            <= 1'b0;
            r_drop           <= 1'b0;
            r_last_slot_done <= 1'b0;
        end else if (w_miss_hs) begin
            r_addr           <= bus.miss_addr_i & LINE_MASK;
            r_beat_cnt       <= '0;
            r_err            <= 1'b0;
            r_drop           <= 1'b0;
            r_last_slot_done <= 1'b0;
        end else begin
            if (w_beat_hs) begin
                if (w_at_last) begin
                    r_last_slot_done <= 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
                if (w_beat_bad) begin
                    r_err <= 1'b1;
                end
            end
            // The AXI transaction still runs to completion; only the write is suppressed.
            if (w_flush_hit) begin
                r_drop <= 1'b1;
            end
        end
    end

    icache_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .SLOTS      (BEATS),
        .IDX_W      (IDX_W)
    ) u_line_buffer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we_i   (w_buf_we),
        .idx_i  (r_beat_cnt),
        .data_i (bus.beat_data_i),
        .line_o (w_fill_line)
    );

    assign bus.line_req_addr_o = r_addr;
    assign bus.fill_addr_o     = r_addr;
    assign bus.fill_line_o     = w_fill_line;
    assign bus.busy_o          = (r_state != IDLE);

endmodule

// File: tb/tb_icache_refill_unit.sv
// Scenario bench for icache_refill_unit: expected fills are queued when a miss is
// driven and matched against fills captured from the unit.
module tb_icache_refill_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   req_bad  = 0;
    int   busy_bad = 0;

    typedef struct {
        bit           we;
        bit           err;
        logic [31:0]  addr;
        logic [255:0] line;
        bit           chk_line;
        int           cyc;
    } fill_t;

    fill_t exp_q[$];
    fill_t obs_q[$];
    fill_t mon_f;

    localparam logic [255:0] LINE_NOM = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

    icache_refill_unit_if bus_if ();

    icache_refill_unit dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.fill_we_o || bus_if.fill_err_o) begin
            mon_f.we       = bus_if.fill_we_o;
            mon_f.err      = bus_if.fill_err_o;
            mon_f.addr     = bus_if.fill_addr_o;
            mon_f.line     = bus_if.fill_line_o;
            mon_f.chk_line = 1'b1;
            mon_f.cyc      = cyc;
            obs_q.push_back(mon_f);
            $display("fill  addr=%h we=%0b err=%0b cycle=%0d", mon_f.addr, mon_f.we, mon_f.err, cyc);
        end
    end

    function automatic logic [63:0] pat(input int i);
        logic [7:0] b;
        b = 8'(17 * (i + 1));
        return {8{b}};
    endfunction

    // Runs one refill from IDLE; flush_at: [0] REQ, [1] beat 1, [2] last beat, [3] FILL cycle.
    task automatic do_refill(input logic [31:0] addr, input logic [31:0] line_addr,
                             input int nbeats, input int last_at, input int err_beat,
                             input int req_stall, input bit gaps, input logic [3:0] flush_at,
                             input int stop_before);
        $display("miss  addr=%h beats=%0d last=%0d err_beat=%0d stall=%0d flush=%b",
                 addr, nbeats, last_at, err_beat, req_stall, flush_at);
        bus_if.miss_valid_i = 1'b1;
        bus_if.miss_addr_i  = addr;
        @(posedge clk); #1;
        bus_if.miss_valid_i = 1'b0;
        bus_if.miss_addr_i  = $urandom;
        for (int s = 0; s <= req_stall; s++) begin
            bus_if.line_req_ready_i = (s == req_stall);
            bus_if.flush_i = flush_at[0] && (s == 0);
            if (gaps) begin
                bus_if.beat_valid_i = 1'b1;
                bus_if.beat_data_i  = pat(0);
                bus_if.beat_last_i  = (last_at == 0);
                bus_if.beat_resp_i  = 2'b00;
            end
            if (bus_if.line_req_valid_o !== 1'b1 || bus_if.line_req_addr_o !== line_addr) req_bad++;
            if (bus_if.busy_o !== 1'b1) busy_bad++;
            @(posedge clk); #1;
        end
        bus_if.line_req_ready_i = 1'b0;
        bus_if.flush_i = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (i == stop_before) return;
            if (gaps && (i % 2 == 1)) begin
                bus_if.beat_valid_i = 1'b0;
                bus_if.flush_i      = 1'b0;
                if (bus_if.busy_o !== 1'b1) busy_bad++;
                @(posedge clk); #1;
            end
            bus_if.beat_valid_i = 1'b1;
            bus_if.beat_data_i  = pat(i);
            bus_if.beat_last_i  = (i == last_at);
            bus_if.beat_resp_i  = (i == err_beat) ? 2'b10 : 2'b00;
            bus_if.flush_i      = (flush_at[1] && i == 1) || (flush_at[2] && i == last_at);
            if (bus_if.busy_o !== 1'b1) busy_bad++;
            @(posedge clk); #1;
        end
        bus_if.beat_valid_i = 1'b0;
        bus_if.beat_last_i  = 1'b0;
        bus_if.beat_resp_i  = 2'b00;
        bus_if.flush_i      = flush_at[3];
        if (bus_if.busy_o !== 1'b1) busy_bad++;
        @(posedge clk); #1;
        bus_if.flush_i = 1'b0;
    endtask

    task automatic pop_fill(output fill_t e, output fill_t o, output bit got);
        e   = exp_q.pop_front();
        got = (obs_q.size() != 0);
        if (got) o = obs_q.pop_front();
    endtask

    task automatic test_reset();
        bus_if.miss_valid_i = 0; bus_if.miss_addr_i = '0; bus_if.flush_i = 0;
        bus_if.line_req_ready_i = 0; bus_if.beat_valid_i = 0; bus_if.beat_data_i = '0;
        bus_if.beat_last_i = 0; bus_if.beat_resp_i = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_if.miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_miss_ready: got %b expected 1", bus_if.miss_ready_o); end
        n_checks++; if (bus_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus_if.busy_o); end
        n_checks++; if (bus_if.line_req_valid_o !== 1'b0 || bus_if.beat_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_handshake: got req=%b beat_ready=%b expected 0/0", bus_if.line_req_valid_o, bus_if.beat_ready_o); end
        n_checks++; if (bus_if.fill_we_o !== 1'b0 || bus_if.fill_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_fill: got we=%b err=%b expected 0/0", bus_if.fill_we_o, bus_if.fill_err_o); end
        n_checks++; if (bus_if.line_req_addr_o !== 32'h0 || bus_if.fill_line_o !== 256'h0) begin n_fail++; $display("FAIL rst_data: got addr=%h line=%h expected zeros", bus_if.line_req_addr_o, bus_if.fill_line_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        fill_t e, o;
        bit got;
        e = '{we: 1'b1, err: 1'b0, addr: 32'h0000_1220, line: LINE_NOM, chk_line: 1'b1, cyc: cyc + 6};
        exp_q.push_back(e);
        do_refill(32'h0000_1234, 32'h0000_1220, 4, 3, -1, 0, 1'b0, 4'b0000, -1);
        n_checks++; if (bus_if.miss_ready_o !== 1'b1 || bus_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL nom_idle_at_7: got ready=%b busy=%b expected 1/0", bus_if.miss_ready_o, bus_if.busy_o); end
        n_checks++; if (req_bad != 0) begin n_fail++; $display("FAIL nom_req_addr: got %0d bad cycles expected 0", req_bad); end
        pop_fill(e, o, got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL nom_present: got no fill expected one"); end
        else begin
            n_checks++; if (o.we !== e.we || o.err !== e.err) begin n_fail++; $display("FAIL nom_flags: got we=%b err=%b expected %b/%b", o.we, o.err, e.we, e.err); end
            n_checks++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL nom_addr: got %h expected %h", o.addr, e.addr); end
            n_checks++; if (o.line !== e.line) begin n_fail++; $display("FAIL nom_line: got %h expected %h", o.line, e.line); end
            n_checks++; if (o.cyc != e.cyc) begin n_fail++; $display("FAIL nom_latency: got cycle %0d expected %0d", o.cyc, e.cyc); end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL nom_single_pulse: got %0d extra fills expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_backpressure();
        fill_t e, o;
        bit got;
        req_bad = 0; busy_bad = 0;
        e = '{we: 1'b1, err: 1'b0, addr: 32'h0000_1220, line: LINE_NOM, chk_line: 1'b1, cyc: 0};
        exp_q.push_back(e);
        do_refill(32'h0000_1234, 32'h0000_1220, 4, 3, -1, 3, 1'b1, 4'b0000, -1);
        n_checks++; if (req_bad != 0) begin n_fail++; $display("FAIL bp_addr_stable: got %0d bad cycles expected 0", req_bad); end
        n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL bp_busy: got %0d low cycles expected 0", busy_bad); end
        pop_fill(e, o, got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL bp_present: got no fill expected one"); end
        else begin
            n_checks++; if (o.we !== 1'b1 || o.err !== 1'b0 || o.addr !== e.addr) begin n_fail++; $display("FAIL bp_fill: got we=%b err=%b addr=%h expected 1/0/%h", o.we, o.err, o.addr, e.addr); end
            n_checks++; if (o.line !== e.line) begin n_fail++; $display("FAIL bp_line: got %h expected %h", o.line, e.line); end
        end
        obs_q.delete();
    endtask

    task automatic test_errors();
        fill_t e, o;
        bit got;
        // beat 2 returns SLVERR
        e = '{we: 1'b0, err: 1'b1, addr: 32'h8000_0040, line: LINE_NOM, chk_line: 1'b1, cyc: cyc + 6};
        exp_q.push_back(e);
        do_refill(32'h8000_005c, 32'h8000_0040, 4, 3, 2, 0, 1'b0, 4'b0000, -1);
        // short burst: last on beat 1
        e = '{we: 1'b0, err: 1'b1, addr: 32'h0000_0a00, line: '0, chk_line: 1'b0, cyc: cyc + 4};
        exp_q.push_back(e);
        do_refill(32'h0000_0a1f, 32'h0000_0a00, 2, 1, -1, 0, 1'b0, 4'b0000, -1);
        // long burst: 5 beats, the fifth (0x55..) must not reach the line
        e = '{we: 1'b0, err: 1'b1, addr: 32'h0000_0b20, line: LINE_NOM, chk_line: 1'b1, cyc: cyc + 7};
        exp_q.push_back(e);
        do_refill(32'h0000_0b27, 32'h0000_0b20, 5, 4, -1, 0, 1'b0, 4'b0000, -1);
        for (int k = 0; k < 3; k++) begin
            pop_fill(e, o, got);
            n_checks++;
            if (!got) begin n_fail++; $display("FAIL err%0d_present: got no fill expected one", k); end
            else begin
                n_checks++; if (o.we !== 1'b0 || o.err !== 1'b1) begin n_fail++; $display("FAIL err%0d_flags: got we=%b err=%b expected 0/1", k, o.we, o.err); end
                n_checks++; if (o.addr !== e.addr || o.cyc != e.cyc) begin n_fail++; $display("FAIL err%0d_addr_cycle: got %h@%0d expected %h@%0d", k, o.addr, o.cyc, e.addr, e.cyc); end
                if (e.chk_line) begin
                    n_checks++; if (o.line !== e.line) begin n_fail++; $display("FAIL err%0d_line: got %h expected %h", k, o.line, e.line); end
                end
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL err_single_pulse: got %0d extra fills expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_flush();
        fill_t e, o;
        bit got;
        logic [3:0] masks [3] = '{4'b0001, 4'b0010, 4'b0100};
        for (int k = 0; k < 3; k++) begin
            do_refill(32'h0000_3000 + 32'(k * 64), 32'h0000_3000 + 32'(k * 64), 4, 3,
                      (k == 1) ? 2 : -1, 0, 1'b0, masks[k], -1);
            n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL flush%0d_nofill: got %0d fills expected 0", k, obs_q.size()); obs_q.delete(); end
            n_checks++; if (bus_if.miss_ready_o !== 1'b1 || bus_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush%0d_idle: got ready=%b busy=%b expected 1/0", k, bus_if.miss_ready_o, bus_if.busy_o); end
        end
        // flush during FILL itself is ignored
        e = '{we: 1'b1, err: 1'b0, addr: 32'h0000_3100, line: LINE_NOM, chk_line: 1'b1, cyc: cyc + 6};
        exp_q.push_back(e);
        do_refill(32'h0000_3104, 32'h0000_3100, 4, 3, -1, 0, 1'b0, 4'b1000, -1);
        pop_fill(e, o, got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL flush_in_fill_present: got no fill expected one"); end
        else begin
            n_checks++; if (o.we !== 1'b1 || o.addr !== e.addr || o.cyc != e.cyc) begin n_fail++; $display("FAIL flush_in_fill: got we=%b %h@%0d expected 1 %h@%0d", o.we, o.addr, o.cyc, e.addr, e.cyc); end
        end
    endtask

    task automatic test_reset_mid();
        fill_t e, o;
        bit got;
        do_refill(32'h0000_5000, 32'h0000_5000, 4, 3, -1, 0, 1'b0, 4'b0000, 2);
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus_if.miss_ready_o !== 1'b1 || bus_if.busy_o !== 1'b0 || bus_if.beat_ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got ready=%b busy=%b beat_ready=%b expected 1/0/0", bus_if.miss_ready_o, bus_if.busy_o, bus_if.beat_ready_o); end
        n_checks++; if (bus_if.line_req_addr_o !== 32'h0 || bus_if.fill_line_o !== 256'h0) begin n_fail++; $display("FAIL midrst_data: got addr=%h line=%h expected zeros", bus_if.line_req_addr_o, bus_if.fill_line_o); end
        bus_if.beat_valid_i = 1'b0; bus_if.beat_last_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_nofill: got %0d fills expected 0", obs_q.size()); obs_q.delete(); end
        e = '{we: 1'b1, err: 1'b0, addr: 32'h0000_2460, line: LINE_NOM, chk_line: 1'b1, cyc: cyc + 6};
        exp_q.push_back(e);
        do_refill(32'h0000_2468, 32'h0000_2460, 4, 3, -1, 0, 1'b0, 4'b0000, -1);
        pop_fill(e, o, got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL midrst_recover_present: got no fill expected one"); end
        else begin
            n_checks++; if (o.we !== 1'b1 || o.addr !== e.addr || o.line !== e.line || o.cyc != e.cyc) begin n_fail++; $display("FAIL midrst_recover: got we=%b %h@%0d line=%h expected 1 %h@%0d", o.we, o.addr, o.cyc, o.line, e.addr, e.cyc); end
        end
    endtask

    task automatic test_back_to_back();
        fill_t e, o;
        bit got;
        e = '{we: 1'b1, err: 1'b0, addr: 32'h0000_0100, line: LINE_NOM, chk_line: 1'b1, cyc: cyc + 6};
        exp_q.push_back(e);
        do_refill(32'h0000_0108, 32'h0000_0100, 4, 3, -1, 0, 1'b0, 4'b0000, -1);
        e = '{we: 1'b1, err: 1'b0, addr: 32'hffff_ffe0, line: LINE_NOM, chk_line: 1'b1, cyc: cyc + 6};
        exp_q.push_back(e);
        do_refill(32'hffff_ffff, 32'hffff_ffe0, 4, 3, -1, 0, 1'b0, 4'b0000, -1);
        for (int k = 0; k < 2; k++) begin
            pop_fill(e, o, got);
            n_checks++;
            if (!got) begin n_fail++; $display("FAIL b2b%0d_present: got no fill expected one", k); end
            else begin
                n_checks++; if (o.addr !== e.addr || o.cyc != e.cyc || o.we !== 1'b1) begin n_fail++; $display("FAIL b2b%0d: got we=%b %h@%0d expected 1 %h@%0d", k, o.we, o.addr, o.cyc, e.addr, e.cyc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_errors();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_refill_unit.md
ICACHE_REFILL_UNIT -- requirements
Module: icache_refill_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 Parameter DATA_WIDTH, default 64, read-beat width in bits.
REQ-003 Parameter LINE_BYTES, default 32, cache line size; BEATS = LINE_BYTES*8/DATA_WIDTH (default 4).
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 miss_valid_i  in  1  icache miss request valid.
REQ-007 miss_ready_o  out  1  unit can accept a miss.
REQ-008 miss_addr_i  in  ADDR_WIDTH  faulting fetch byte address.
REQ-009 flush_i  in  1  icache invalidate; the in-flight refill is not written.
REQ-010 line_req_valid_o  out  1  line-fetch request to the AXI icache port.
REQ-011 line_req_ready_i  in  1  AXI icache port accepts the request.
REQ-012 line_req_addr_o  out  ADDR_WIDTH  line-aligned request address.
REQ-013 beat_valid_i  in  1  read beat valid from the port.
REQ-014 beat_ready_o  out  1  unit accepts the beat.
REQ-015 beat_data_i  in  DATA_WIDTH  beat payload.
REQ-016 beat_last_i  in  1  final beat of the burst.
REQ-017 beat_resp_i  in  2  AXI RRESP; non-zero means error.
REQ-018 fill_we_o  out  1  one-cycle write strobe to the icache data/tag arrays.
REQ-019 fill_addr_o  out  ADDR_WIDTH  line-aligned address of the fill.
REQ-020 fill_line_o  out  LINE_BYTES*8  assembled line; beat k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-021 fill_err_o  out  1  one-cycle pulse: the refill completed with an error.
REQ-022 busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-023 The FSM SHALL have exactly four states: IDLE, REQ, COLLECT, FILL.
REQ-024 IDLE behaviour:
- miss_ready_o = 1.
- On the miss handshake, latch miss_addr_i with its low log2(LINE_BYTES) bits zeroed, clear the beat counter and the err/drop flags, and go to REQ.
REQ-025 REQ behaviour:
- line_req_valid_o = 1.
- line_req_addr_o holds the latched address stable until line_req_ready_i.
- On the handshake, go to COLLECT.
REQ-026 COLLECT behaviour:
- beat_ready_o = 1.
- Each beat handshake writes beat_data_i into slot beat_cnt, then increments beat_cnt.
- beat_cnt saturates at BEATS-1.
REQ-027 Error flag (sticky), set by any accepted beat with:
- beat_resp_i != 0;
- beat_last_i at beat_cnt != BEATS-1 (short burst);
- beat_cnt == BEATS-1 without beat_last_i (long burst; the extra beat's data is discarded, slot BEATS-1 is kept).
REQ-028 COLLECT SHALL leave for FILL only on a handshake with beat_last_i = 1.
REQ-029 flush_i in REQ or COLLECT (including the FILL-entry cycle) SHALL set a sticky drop flag. The request and beat handshakes still complete; AXI requests are never abandoned.
REQ-030 flush_i in IDLE or FILL SHALL have no effect.
REQ-031 FILL SHALL last exactly one cycle, then return to IDLE:
- fill_we_o = !err && !drop;
- fill_err_o = err && !drop;
- fill_addr_o and fill_line_o are valid that cycle.
REQ-032 fill_we_o and fill_err_o SHALL be 0 outside FILL.
REQ-033 line_req_valid_o SHALL be 0 outside REQ, and beat_ready_o SHALL be 0 outside COLLECT.
REQ-034 Latency, zero-wait port: miss handshake at cycle 0, request handshake at cycle 1, beats at cycles 2..BEATS+1, fill_we_o at cycle BEATS+2. A new miss is accepted at BEATS+3.
REQ-035 Beats arriving while beat_ready_o = 0 SHALL be left pending and not consumed.

Reset
REQ-036 Reset values:
- state = IDLE; miss_ready_o = 1 (combinational from IDLE).
- All other outputs = 0.
- Beat counter, err, drop and latched address = 0.
REQ-037 Reset mid-refill SHALL abort with no fill strobe. Port-side recovery is the interconnect's responsibility.

Structure
REQ-038 The state enum (icache_refill_state_e) and the BEATS/LINE_BYTES constants SHALL live in interconnect_pkg.
REQ-039 The line storage SHALL be one sub-module, icache_line_buffer: a beat-indexed register array with write-enable and index inputs, and a flat line output.

Verification
REQ-040 Nominal: miss 0x0000_1234, zero-wait, beats 0x11..,0x22..,0x33..,0x44.. with last on beat 3 -> line_req_addr_o = 0x0000_1220, single fill_we_o pulse at cycle 6, fill_line_o = {0x44..,0x33..,0x22..,0x11..}.
REQ-041 Backpressure: line_req_ready_i low 3 cycles, beat_valid_i gaps -> address stable throughout, fill identical to REQ-040, busy_o held high throughout.
REQ-042 Error: beat 2 with resp = 2'b10 -> fill_we_o = 0, fill_err_o pulses once.
REQ-043 Short burst: last on beat 1 -> fill_err_o = 1. Long burst: 5 beats -> fill_err_o = 1, and the 5th beat's data is not in the line.
REQ-044 Flush: flush_i pulsed in REQ and separately in COLLECT -> all beats consumed, no fill_we_o, no fill_err_o, return to IDLE.
REQ-045 Reset: rst_ni asserted during beat 2 -> outputs at reset values immediately, then a new miss completes normally.
